// File: rtl/branch_resolve_if.sv
// Execute-stage to branch-resolve bus: ALU flags and branch request in, PC-select/flush/statistics out.
interface branch_resolve_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             valid_in;
    logic             branch;
    logic [2:0]       cond;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_ltu;
    logic [XLEN-1:0]  target_in;
    logic             clear_stats;
    logic             pc_src;
    logic [XLEN-1:0]  target_out;
    logic             flush;
    logic             illegal_cond;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall, valid_in, branch, cond, alu_zero, alu_lt, alu_ltu, target_in, clear_stats,
        input  pc_src, target_out, flush, illegal_cond, branch_count, taken_count
    );

    modport slave (
        input  stall, valid_in, branch, cond, alu_zero, alu_lt, alu_ltu, target_in, clear_stats,
        output pc_src, target_out, flush, illegal_cond, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches from ALU flags, registers pc_src/target, drives a
// multi-cycle wrong-path flush and keeps saturating branch/taken statistics.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clock,
    input  logic            reset,
    branch_resolve_if.slave bus
);
    localparam int unsigned      FCNT_W     = 4;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [FCNT_W-1:0] flush_cnt;
    logic              pc_src_q;
    logic [XLEN-1:0]   target_q;
    logic              flush_q;
    logic              illegal_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic cond_true_c;
    logic cond_legal_c;
    logic accept_c;
    logic taken_c;

    // Condition evaluation; reserved encodings evaluate not-taken
    always_comb begin
        cond_true_c  = 1'b0;
        cond_legal_c = 1'b1;
        case (bus.cond)
            3'b000:  cond_true_c = bus.alu_zero;
            3'b001:  cond_true_c = ~bus.alu_zero;
            3'b100:  cond_true_c = bus.alu_lt;
            3'b101:  cond_true_c = ~bus.alu_lt;
            3'b110:  cond_true_c = bus.alu_ltu;
            3'b111:  cond_true_c = ~bus.alu_ltu;
            default: cond_legal_c = 1'b0;
        endcase
    end

    // Branches seen while flushing are on the wrong path and are dropped entirely
    assign accept_c = bus.valid_in & bus.branch & ~bus.stall & (state == IDLE);
    assign taken_c  = accept_c & cond_legal_c & cond_true_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            pc_src_q     <= 1'b0;
            target_q     <= '0;
            flush_q      <= 1'b0;
            illegal_q    <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (!bus.stall) begin
            pc_src_q  <= taken_c;
            illegal_q <= accept_c & ~cond_legal_c;
            if (taken_c) begin
                target_q <= bus.target_in;
            end

            case (state)
                IDLE: begin
                    if (taken_c) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush_q   <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase

            // Clear wins over a same-cycle increment
            if (bus.clear_stats) begin
                branch_cnt_q <= '0;
                taken_cnt_q  <= '0;
            end else begin
                if (accept_c && (branch_cnt_q != CNT_MAX)) begin
                    branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                end
                if (taken_c && (taken_cnt_q != CNT_MAX)) begin
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pc_src       = pc_src_q;
    assign bus.target_out   = target_q;
    assign bus.flush        = flush_q;
    assign bus.illegal_cond = illegal_q;
    assign bus.branch_count = branch_cnt_q;
    assign bus.taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a behavioural model pushes expected outputs per step,
// which are popped and compared one edge later.
module tb_branch_resolve_unit;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned FD     = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int          SATMAX = 15;

    logic clock;
    logic reset;

    branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_DEPTH(FD), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        pc;
        logic        ill;
        logic        fl;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state
    logic        m_pc;
    logic        m_ill;
    logic [31:0] m_tgt;
    int          m_flush_left;
    int          m_bc;
    int          m_tc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 1'b0; m_ill = 1'b0; m_tgt = '0;
        m_flush_left = 0; m_bc = 0; m_tc = 0;
    endtask

    function automatic logic ref_legal(input logic [2:0] c);
        return !(c[2:1] == 2'b01);
    endfunction

    function automatic logic ref_true(input logic [2:0] c, input logic z, input logic lt, input logic ltu);
        logic base;
        if (!c[2])     base = z;
        else if (c[1]) base = ltu;
        else           base = lt;
        return base ^ c[0];
    endfunction

    // Drive one cycle of stimulus, advance the model, compare after the edge
    task automatic step(input logic st, input logic v, input logic br, input logic [2:0] c,
                        input logic z, input logic lt, input logic ltu,
                        input logic [31:0] tgt, input logic clr, input string tag);
        exp_t e;
        exp_t got;
        logic idle;
        logic acc;
        logic tk;
        bus.stall = st; bus.valid_in = v; bus.branch = br; bus.cond = c;
        bus.alu_zero = z; bus.alu_lt = lt; bus.alu_ltu = ltu;
        bus.target_in = tgt; bus.clear_stats = clr;
        if (!st) begin
            idle  = (m_flush_left == 0);
            acc   = v && br && idle;
            tk    = acc && ref_legal(c) && ref_true(c, z, lt, ltu);
            m_pc  = tk;
            m_ill = acc && !ref_legal(c);
            if (tk) m_tgt = tgt;
            if (m_flush_left > 0) m_flush_left--;
            if (tk) m_flush_left = FD;
            if (clr) begin
                m_bc = 0; m_tc = 0;
            end else begin
                if (acc && m_bc < SATMAX) m_bc++;
                if (tk && m_tc < SATMAX) m_tc++;
            end
        end
        e.pc = m_pc; e.ill = m_ill; e.fl = (m_flush_left > 0);
        e.tgt = m_tgt; e.bc = 32'(m_bc); e.tc = 32'(m_tc);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check({tag, ".pc_src"},       32'(bus.pc_src),       32'(got.pc));
            check({tag, ".illegal_cond"}, 32'(bus.illegal_cond), 32'(got.ill));
            check({tag, ".flush"},        32'(bus.flush),        32'(got.fl));
            check({tag, ".target_out"},   bus.target_out,        got.tgt);
            check({tag, ".branch_count"}, 32'(bus.branch_count), got.bc);
            check({tag, ".taken_count"},  32'(bus.taken_count),  got.tc);
        end
    endtask

    task automatic idle_step(input string tag);
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic clear_step();
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "clr");
    endtask

    initial begin
        reset = 1'b0;
        bus.stall = 1'b0; bus.valid_in = 1'b0; bus.branch = 1'b0; bus.cond = 3'b000;
        bus.alu_zero = 1'b0; bus.alu_lt = 1'b0; bus.alu_ltu = 1'b0;
        bus.target_in = '0; bus.clear_stats = 1'b0;
        model_reset();

        #12;
        check("rst.pc_src",       32'(bus.pc_src),       32'd0);
        check("rst.target_out",   bus.target_out,        32'd0);
        check("rst.flush",        32'(bus.flush),        32'd0);
        check("rst.illegal_cond", 32'(bus.illegal_cond), 32'd0);
        check("rst.branch_count", 32'(bus.branch_count), 32'd0);
        check("rst.taken_count",  32'(bus.taken_count),  32'd0);
        reset = 1'b1;

        // Taken BEQ, then flush window
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_1040, 1'b0, "beq_taken");
        idle_step("beq_f1");
        idle_step("beq_f2");
        check("beq.target_out",   bus.target_out,        32'h0000_1040);
        check("beq.branch_count", 32'(bus.branch_count), 32'd1);
        check("beq.taken_count",  32'(bus.taken_count),  32'd1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'hdead_0000, 1'b0, "nonbranch");

        // Not-taken BNE, taken BLTU, not-taken BGE
        clear_step();
        step(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 1'b0, "bne_nt");
        check("bne.taken_count", 32'(bus.taken_count), 32'd0);
        step(1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_2100, 1'b0, "bltu_t");
        idle_step("bltu_f1");
        idle_step("bltu_f2");
        step(1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 32'h0000_2200, 1'b0, "bge_nt");
        step(1'b0, 1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 32'h0000_2300, 1'b0, "blt_t");
        idle_step("blt_f1");
        idle_step("blt_f2");
        step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_2400, 1'b0, "bgeu_t");
        idle_step("bgeu_f1");
        idle_step("bgeu_f2");

        // Wrong-path squash, then back-to-back accept in first IDLE cycle
        clear_step();
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 1'b0, "sq_beq");
        step(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 1'b0, "sq_bne1");
        step(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_4004, 1'b0, "sq_bne2");
        check("sq.taken_count", 32'(bus.taken_count), 32'd1);
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 1'b0, "sq_third");
        check("sq.second_pc_src", 32'(bus.pc_src), 32'd1);
        idle_step("sq_f1");
        idle_step("sq_f2");

        // Reserved condition codes
        step(1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 1'b0, "ill_010");
        check("ill.illegal_cond", 32'(bus.illegal_cond), 32'd1);
        step(1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 32'h0000_6004, 1'b0, "ill_011");
        idle_step("ill_after");

        // Stall in first flush cycle stretches pc_src and flush
        clear_step();
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_7000, 1'b0, "st_taken");
        step(1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_7100, 1'b1, "st_s1");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "st_s2");
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "st_s3");
        check("st.taken_count", 32'(bus.taken_count), 32'd1);
        idle_step("st_f1");
        idle_step("st_f2");
        idle_step("st_done");

        // Asynchronous reset mid-flush
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_8000, 1'b0, "ar_taken");
        #2;
        reset = 1'b0;
        #1;
        check("ar.pc_src",       32'(bus.pc_src),       32'd0);
        check("ar.flush",        32'(bus.flush),        32'd0);
        check("ar.target_out",   bus.target_out,        32'd0);
        check("ar.branch_count", 32'(bus.branch_count), 32'd0);
        check("ar.taken_count",  32'(bus.taken_count),  32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_step("ar_release");

        // Saturation of both counters
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'(32'h0000_9000 + i * 4), 1'b0, "sat_br");
            idle_step("sat_f1");
            idle_step("sat_f2");
        end
        check("sat.taken_count",  32'(bus.taken_count),  32'(SATMAX));
        check("sat.branch_count", 32'(bus.branch_count), 32'(SATMAX));

        // Clear beats a same-cycle taken increment
        step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_a000, 1'b1, "clr_taken");
        check("clr.taken_count",  32'(bus.taken_count),  32'd0);
        check("clr.branch_count", 32'(bus.branch_count), 32'd0);
        check("clr.pc_src",       32'(bus.pc_src),       32'd1);
        idle_step("clr_f1");
        idle_step("clr_f2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the single-flag registered branch AND. It resolves conditional branches from ALU flags for six condition codes and registers the taken decision (pc_src) and branch target. After a taken branch it drives a multi-cycle pipeline flush and squashes wrong-path branches. It also keeps saturating branch/taken statistics. It sits between the execute-stage ALU and the PC-select mux and fetch/decode flush logic.

Parameters:
XLEN, 32, width of branch target / PC
FLUSH_DEPTH, 2, cycles flush is held after a taken branch (legal range 1..15)
CNT_W, 16, width of each statistics counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
stall  in  1  1 = freeze all state and outputs this cycle
valid_in  in  1  execute-stage instruction valid
branch  in  1  instruction is a conditional branch
cond  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
alu_zero  in  1  ALU result (a-b) is zero
alu_lt  in  1  signed a<b
alu_ltu  in  1  unsigned a<b
target_in  in  XLEN  computed branch target
clear_stats  in  1  synchronous clear of both counters
pc_src  out  1  registered taken pulse, selects target_out at PC mux
target_out  out  XLEN  registered target, valid when pc_src=1
flush  out  1  squash younger pipeline stages
illegal_cond  out  1  registered pulse: branch with cond 010/011
branch_count  out  CNT_W  accepted branches
taken_count  out  CNT_W  accepted taken branches

Behaviour:
- Reset (reset=0, asynchronous): pc_src=0, target_out=0, flush=0, illegal_cond=0, both counters=0, FSM=IDLE, flush counter=0. Reset takes effect immediately, including mid-flush.
- Condition eval (combinational): BEQ=zero, BNE=~zero, BLT=lt, BGE=~lt, BLTU=ltu, BGEU=~ltu. cond 010/011 evaluate not-taken.
- Accept = valid_in & branch & ~stall & (FSM==IDLE).
- The accepted branch is taken when accept & cond legal & condition true.
- Latency: inputs are sampled at edge t. pc_src and illegal_cond are high for exactly the cycle after edge t (1-cycle pulse). target_out loads target_in only on a taken branch and otherwise holds its value.
- FSM IDLE: on a taken branch, go to FLUSH with counter=FLUSH_DEPTH-1. flush is registered high from the next cycle.
- FSM FLUSH: flush=1; the counter decrements each non-stalled cycle. When counter=0, return to IDLE and deassert flush. flush is therefore high for exactly FLUSH_DEPTH non-stalled cycles.
- In FLUSH, valid_in/branch are ignored: no pc_src, no count, no illegal_cond (wrong-path squash).
- A back-to-back branch arriving in the first IDLE cycle after FLUSH is accepted normally.
- stall=1: all registers hold, including pc_src, flush, the FSM, the flush counter and the counters. clear_stats is also ignored. A pc_src pulse therefore stretches across the stall.
- Counters: branch_count +1 on every accept (illegal included); taken_count +1 on every taken branch.
- Both counters saturate at 2^CNT_W-1 with no wrap.
- clear_stats has priority over an increment in the same cycle: the result is 0, not 1.
- Non-branch valid instructions have no effect.

Test Plan:
- Reset then BEQ with zero=1, target_in=0x0000_1040 -> pc_src=1 one cycle later for 1 cycle; target_out=0x1040; flush high 2 cycles; branch_count=1, taken_count=1.
- BNE with zero=1 -> pc_src stays 0, flush stays 0; branch_count=1, taken_count=0. Then BLTU with ltu=1 -> taken; BGE with lt=1 -> not taken.
- Taken BEQ followed immediately by a taken BNE on the next two cycles (squash window) -> single pc_src pulse, taken_count=1. A third branch in the first IDLE cycle is accepted -> second pc_src.
- cond=010 with valid branch -> illegal_cond pulse 1 cycle, pc_src=0, branch_count increments.
- stall=1 for 3 cycles during first flush cycle -> flush high for 2+3=5 cycles total, counters frozen. Assert reset=0 mid-flush -> flush, pc_src, counters 0 immediately.
- CNT_W=4: 17 taken branches -> taken_count saturates at 15. clear_stats coincident with a taken branch -> both counters 0.
